hazard_scoreboard: RTL

Parametrised hazard-detection and forwarding-control block for the RISC-V core pipeline, sitting beside the ID stage. It tracks destination registers of in-flight instructions in a shift-register scoreboard with per-entry readiness countdowns. From that it produces the pipeline stall for load-use and multi-cycle hazards, combinational forward selects for early (ID-stage) consumers such as branches and jalr, and registered forward selects for EX-stage operands.

---
 rtl/hazard_scoreboard.sv | 80 ++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations with readiness countdowns to drive
// the ID stall, the ID-stage forward selects and the registered EX-stage forward selects.
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int ADDR_W  = 5,
  parameter int SEL_W   = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      flush,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC-1:0]        id_early,
  input  logic [ADDR_W-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic [SEL_W-1:0]          id_lat,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  id_fwd_sel,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel
);
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]    rd_q, rd_d;
  logic [DEPTH-1:0][SEL_W-1:0]     rdy_q, rdy_d;
  logic [NUM_SRC*SEL_W-1:0]        ex_fwd_q, ex_fwd_d;
  logic [NUM_SRC-1:0]              hit, haz;
  logic [NUM_SRC-1:0][SEL_W-1:0]   idx, mrdy;
  logic [SEL_W-1:0]                lat_c;
  logic                            load;
  // Scanning oldest to youngest lets the youngest matching producer overwrite the result.
  always_comb begin
    hit  = '0;
    idx  = '0;
    mrdy = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int i = DEPTH-1; i >= 0; i--)
        if (id_rs_used[s] && id_rs[s*ADDR_W +: ADDR_W] != '0 && valid_q[i] &&
            rd_q[i] == id_rs[s*ADDR_W +: ADDR_W]) begin
          hit[s]  = 1'b1;
          idx[s]  = SEL_W'(i);
          mrdy[s] = rdy_q[i];
        end
  end
  always_comb begin
    haz        = '0;
    id_fwd_sel = '0;
    ex_fwd_d   = '0;
    for (int s = 0; s < NUM_SRC; s++)
      haz[s] = hit[s] & (id_early[s] ? (mrdy[s] != '0) : (mrdy[s] > SEL_W'(1)));
    stall = id_valid & ~flush & (|haz);
    for (int s = 0; s < NUM_SRC; s++) begin
      id_fwd_sel[s*SEL_W +: SEL_W] = (hit[s] & id_early[s] & ~haz[s]) ? idx[s] : '0;
      ex_fwd_d[s*SEL_W +: SEL_W] = (id_valid & ~flush & ~stall & hit[s] & ~id_early[s] &
                                    (idx[s] != SEL_W'(DEPTH-1))) ? idx[s] + 1'b1 : '0;
    end
    lat_c = (id_lat == '0) ? SEL_W'(1) :
            (id_lat > SEL_W'(DEPTH-1)) ? SEL_W'(DEPTH-1) : id_lat;
    load    = id_valid & ~stall & ~flush & id_regwrite & (id_rd != '0);
    valid_d = {valid_q[DEPTH-2:0], load};
    rd_d    = {rd_q[DEPTH-2:0], id_rd};
    rdy_d[0] = lat_c;
    for (int k = 0; k < DEPTH-1; k++)
      rdy_d[k+1] = (rdy_q[k] == '0) ? '0 : rdy_q[k] - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rd_q     <= '0;
      rdy_q    <= '0;
      ex_fwd_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      rdy_q    <= rdy_d;
      ex_fwd_q <= ex_fwd_d;
    end
  end
  assign ex_fwd_sel = ex_fwd_q;
endmodule
